// File: rtl/idma_nd_midend_2d.sv
// 2D iDMA midend: unrolls one 2D descriptor into `reps` strided 1D bursts and tracks completions.
// Optional build macro IDMA_ND_MIDEND_ZERO_SKIP_EN: zero-length descriptors complete without issuing bursts.
module idma_nd_midend_2d #(
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned LenWidth   = 64,
    parameter int unsigned RepWidth   = 64,
    parameter int unsigned OptWidth   = 32,
    parameter int unsigned OutstWidth = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  nd_req_valid_i,
    output logic                  nd_req_ready_o,
    input  logic [AddrWidth-1:0]  nd_src_addr_i,
    input  logic [AddrWidth-1:0]  nd_dst_addr_i,
    input  logic [LenWidth-1:0]   nd_length_i,
    input  logic [RepWidth-1:0]   nd_reps_i,
    input  logic [AddrWidth-1:0]  nd_src_stride_i,
    input  logic [AddrWidth-1:0]  nd_dst_stride_i,
    input  logic [OptWidth-1:0]   nd_opt_i,
    output logic                  burst_valid_o,
    input  logic                  burst_ready_i,
    output logic [AddrWidth-1:0]  burst_src_addr_o,
    output logic [AddrWidth-1:0]  burst_dst_addr_o,
    output logic [LenWidth-1:0]   burst_length_o,
    output logic [OptWidth-1:0]   burst_opt_o,
    output logic                  burst_last_o,
    input  logic                  rsp_valid_i,
    input  logic                  rsp_last_i,
    output logic                  nd_done_o,
    output logic                  busy_o
);

    // Handshakes: a transfer occurs on a rising clk edge where valid && ready;
    // once valid is raised, the payload holds until that transfer happens.

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [OutstWidth-1:0] OutstOne = OutstWidth'(1);
    localparam logic [OutstWidth-1:0] OutstMax = {OutstWidth{1'b1}};
    localparam logic [RepWidth-1:0]   RepOne   = RepWidth'(1);

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   src_q, dst_q, src_stride_q, dst_stride_q;
    logic [LenWidth-1:0]    len_q;
    logic [OptWidth-1:0]    opt_q;
    logic [RepWidth-1:0]    rem_q;
    logic [OutstWidth-1:0]  outst_q, outst_d;
    logic                   done_q, done_d;
    logic                   busy_q;
    logic                   accept, zero_skip, burst_hs, rsp_take, rsp_done;

    assign nd_req_ready_o   = (state_q == IDLE) && !rst_i;
    assign burst_valid_o    = (state_q == RUN) && (outst_q != OutstMax);
    assign burst_last_o     = (rem_q == RepOne);
    assign burst_src_addr_o = src_q;
    assign burst_dst_addr_o = dst_q;
    assign burst_length_o   = len_q;
    assign burst_opt_o      = opt_q;
    assign nd_done_o        = done_q;
    assign busy_o           = busy_q;

    assign accept   = nd_req_valid_i && nd_req_ready_o;
    assign burst_hs = burst_valid_o && burst_ready_i;
    assign rsp_take = rsp_valid_i && (outst_q != '0);
    assign rsp_done = rsp_take && rsp_last_i;

`ifdef IDMA_ND_MIDEND_ZERO_SKIP_EN
    logic skip_pend_q, skip_pend_d;

    assign zero_skip = accept && (nd_length_i == '0);

    // A skip completion colliding with a response completion waits one cycle.
    always_comb begin
        done_d      = rsp_done || zero_skip || skip_pend_q;
        skip_pend_d = skip_pend_q ? (zero_skip || rsp_done) : (zero_skip && rsp_done);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) skip_pend_q <= 1'b0;
        else       skip_pend_q <= skip_pend_d;
    end
`else
    assign zero_skip = 1'b0;
    assign done_d    = rsp_done;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !zero_skip) state_d = RUN;
            RUN:  if (burst_hs && burst_last_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        if (burst_hs && !rsp_take)      outst_d = outst_q + OutstOne;
        else if (!burst_hs && rsp_take) outst_d = outst_q - OutstOne;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            outst_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
            done_q  <= done_d;
            busy_q  <= (state_d == RUN) || (outst_d != '0);
        end
    end

    // Address generation; strides are two's complement and wrap silently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q        <= '0;
            dst_q        <= '0;
            src_stride_q <= '0;
            dst_stride_q <= '0;
            len_q        <= '0;
            opt_q        <= '0;
            rem_q        <= '0;
        end else if (accept) begin
            src_q        <= nd_src_addr_i;
            dst_q        <= nd_dst_addr_i;
            src_stride_q <= nd_src_stride_i;
            dst_stride_q <= nd_dst_stride_i;
            len_q        <= nd_length_i;
            opt_q        <= nd_opt_i;
            rem_q        <= (nd_reps_i == '0) ? RepOne : nd_reps_i;
        end else if (burst_hs) begin
            src_q <= src_q + src_stride_q;
            dst_q <= dst_q + dst_stride_q;
            rem_q <= rem_q - RepOne;
        end
    end

endmodule

// File: tb/tb_idma_nd_midend_2d.sv
// Directed bench for idma_nd_midend_2d: vector table plus hand-timed corner sequences.
module tb_idma_nd_midend_2d;

  localparam int AW  = 64;
  localparam int LW  = 64;
  localparam int RW  = 64;
  localparam int OW  = 32;
  localparam int OSW = 2;

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic [RW-1:0] reps;
    logic [AW-1:0] ss;
    logic [AW-1:0] ds;
    logic [OW-1:0] opt;
    int            n;
    logic [AW-1:0] last_src;
    logic [AW-1:0] last_dst;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          nd_valid = 1'b0;
  logic          nd_ready;
  logic [AW-1:0] nd_src = '0, nd_dst = '0, nd_ss = '0, nd_ds = '0;
  logic [LW-1:0] nd_len = '0;
  logic [RW-1:0] nd_reps = '0;
  logic [OW-1:0] nd_opt = '0;
  logic          b_valid;
  logic          b_ready = 1'b0;
  logic [AW-1:0] b_src, b_dst;
  logic [LW-1:0] b_len;
  logic [OW-1:0] b_opt;
  logic          b_last;
  logic          rsp_valid = 1'b0;
  logic          rsp_last = 1'b0;
  logic          nd_done;
  logic          busy;

  int n_total = 0;
  int n_bad = 0;
  int n_bursts = 0;
  int n_done = 0;

  logic [AW-1:0] exp_src_q[$];
  logic [AW-1:0] exp_dst_q[$];
  logic [LW-1:0] exp_len_q[$];
  logic [0:0]    exp_last_q[$];
  logic [OW-1:0] cur_opt = '0;

  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_src, prev_dst;
  logic [LW-1:0] prev_len;
  logic          prev_last;

  vec_t vecs[4];

  idma_nd_midend_2d #(
    .AddrWidth(AW), .LenWidth(LW), .RepWidth(RW), .OptWidth(OW), .OutstWidth(OSW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .nd_req_valid_i(nd_valid), .nd_req_ready_o(nd_ready),
    .nd_src_addr_i(nd_src), .nd_dst_addr_i(nd_dst), .nd_length_i(nd_len),
    .nd_reps_i(nd_reps), .nd_src_stride_i(nd_ss), .nd_dst_stride_i(nd_ds),
    .nd_opt_i(nd_opt),
    .burst_valid_o(b_valid), .burst_ready_i(b_ready),
    .burst_src_addr_o(b_src), .burst_dst_addr_o(b_dst), .burst_length_o(b_len),
    .burst_opt_o(b_opt), .burst_last_o(b_last),
    .rsp_valid_i(rsp_valid), .rsp_last_i(rsp_last),
    .nd_done_o(nd_done), .busy_o(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: burst payload, stall stability, done counting
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(b_valid), 64'd1);
        check("stall_src", b_src, prev_src);
        check("stall_dst", b_dst, prev_dst);
        check("stall_len", b_len, prev_len);
        check("stall_last", 64'(b_last), 64'(prev_last));
      end
      if (b_valid && b_ready) begin
        n_bursts++;
        if (exp_src_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_burst: got src %h expected no burst", b_src);
        end else begin
          check("burst_src", b_src, exp_src_q.pop_front());
          check("burst_dst", b_dst, exp_dst_q.pop_front());
          check("burst_len", b_len, exp_len_q.pop_front());
          check("burst_last", 64'(b_last), 64'(exp_last_q.pop_front()));
          check("burst_opt", 64'(b_opt), 64'(cur_opt));
        end
      end
      if (nd_done) n_done++;
      prev_stall = b_valid && !b_ready;
      prev_src   = b_src;
      prev_dst   = b_dst;
      prev_len   = b_len;
      prev_last  = b_last;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input vec_t v);
    logic [AW-1:0] s, d;
    s = v.src;
    d = v.dst;
    for (int i = 0; i < v.n; i++) begin
      exp_src_q.push_back(s);
      exp_dst_q.push_back(d);
      exp_len_q.push_back(v.len);
      exp_last_q.push_back(1'(i == v.n - 1));
      s = s + v.ss;
      d = d + v.ds;
    end
  endtask

  task automatic drive_desc(input vec_t v);
    nd_valid = 1'b1;
    nd_src = v.src;
    nd_dst = v.dst;
    nd_len = v.len;
    nd_reps = v.reps;
    nd_ss = v.ss;
    nd_ds = v.ds;
    nd_opt = v.opt;
    @(negedge clk);
    check("req_ready", 64'(nd_ready), 64'd1);
    step();
    cur_opt = v.opt;
    nd_valid = 1'b0;
  endtask

  task automatic send_rsps(input int n);
    for (int i = 0; i < n; i++) begin
      rsp_valid = 1'b1;
      rsp_last = (i == n - 1);
      step();
    end
    rsp_valid = 1'b0;
    rsp_last = 1'b0;
  endtask

  task automatic check_done_pulse(input string name);
    @(negedge clk);
    check({name, "_done"}, 64'(nd_done), 64'd1);
    check({name, "_busy_low"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({name, "_done_single"}, 64'(nd_done), 64'd0);
  endtask

  initial begin
    vec_t v;
    int   b0, d0;

    vecs[0] = '{src:64'h1000, dst:64'h8000, len:64'd64, reps:64'd3, ss:64'h100, ds:64'h40,
                opt:32'hA5A5_0001, n:3, last_src:64'h1200, last_dst:64'h8080};
    vecs[1] = '{src:64'h2000, dst:64'h3000, len:64'd16, reps:64'd0, ss:64'h10, ds:64'h10,
                opt:32'h0000_0002, n:1, last_src:64'h2000, last_dst:64'h3000};
    vecs[2] = '{src:64'h2400, dst:64'h3400, len:64'd32, reps:64'd1, ss:64'h10, ds:64'h10,
                opt:32'h0000_0003, n:1, last_src:64'h2400, last_dst:64'h3400};
    vecs[3] = '{src:64'h2000, dst:64'h100, len:64'd8, reps:64'd2, ss:64'hFFFF_FFFF_FFFF_FFF0, ds:64'h0,
                opt:32'h0000_0004, n:2, last_src:64'h1FF0, last_dst:64'h100};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(nd_ready), 64'd0);
    check("rst_valid", 64'(b_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(nd_done), 64'd0);
    check("rst_src", b_src, 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(nd_ready), 64'd1);
    check("post_rst_valid", 64'(b_valid), 64'd0);

    // table: full-rate unroll, then complete all responses
    for (int k = 0; k < 4; k++) begin
      v = vecs[k];
      step();
      b_ready = 1'b1;
      d0 = n_done;
      push_exp(v);
      drive_desc(v);
      for (int i = 0; i < v.n; i++) begin
        @(negedge clk);
        check("vec_valid", 64'(b_valid), 64'd1);
        if (i == 0) check("vec_busy", 64'(busy), 64'd1);
        if (i == v.n - 1) begin
          check("vec_last_src", b_src, v.last_src);
          check("vec_last_dst", b_dst, v.last_dst);
        end
      end
      @(negedge clk);
      check("vec_valid_after", 64'(b_valid), 64'd0);
      step();
      send_rsps(v.n);
      check_done_pulse("vec");
      check("vec_done_count", 64'(n_done - d0), 64'd1);
      check("vec_exp_empty", 64'(exp_src_q.size()), 64'd0);
    end

    // backpressure and address wrap
    v = '{src:64'hFFFF_FFFF_FFFF_FFC0, dst:64'h0, len:64'd8, reps:64'd2, ss:64'h40, ds:64'h10,
          opt:32'h0000_0005, n:2, last_src:64'h0, last_dst:64'h10};
    step();
    b_ready = 1'b0;
    b0 = n_bursts;
    push_exp(v);
    drive_desc(v);
    @(negedge clk);
    check("bp_first_src", b_src, 64'hFFFF_FFFF_FFFF_FFC0);
    step(); b_ready = 1'b1;
    step(); b_ready = 1'b0;
    @(negedge clk);
    check("bp_wrap_src", b_src, v.last_src);
    step(); b_ready = 1'b1;
    step();
    @(negedge clk);
    check("bp_valid_after", 64'(b_valid), 64'd0);
    check("bp_count", 64'(n_bursts - b0), 64'd2);
    step();
    send_rsps(2);
    check_done_pulse("bp");

    // outstanding limit: 3 in flight with a 2-bit counter
    v = '{src:64'h3000, dst:64'h4000, len:64'd16, reps:64'd5, ss:64'h10, ds:64'h20,
          opt:32'h0000_0006, n:5, last_src:64'h3040, last_dst:64'h4080};
    step();
    b_ready = 1'b1;
    b0 = n_bursts;
    push_exp(v);
    drive_desc(v);
    repeat (3) step();
    @(negedge clk);
    check("lim_valid_low", 64'(b_valid), 64'd0);
    step();
    @(negedge clk);
    check("lim_count3", 64'(n_bursts - b0), 64'd3);
    step();
    rsp_valid = 1'b1;
    @(negedge clk);
    check("lim_no_comb", 64'(b_valid), 64'd0);
    step();
    rsp_valid = 1'b0;
    @(negedge clk);
    check("lim_refill", 64'(b_valid), 64'd1);
    step();
    @(negedge clk);
    check("lim_full_again", 64'(b_valid), 64'd0);
    check("lim_count4", 64'(n_bursts - b0), 64'd4);
    step();
    send_rsps(4);
    check_done_pulse("lim");
    check("lim_count5", 64'(n_bursts - b0), 64'd5);

    // overlap: next descriptor right after last handshake, issue+response same cycle
    v = '{src:64'h5000, dst:64'h6000, len:64'd32, reps:64'd2, ss:64'h100, ds:64'h100,
          opt:32'h0000_0007, n:2, last_src:64'h5100, last_dst:64'h6100};
    step();
    d0 = n_done;
    push_exp(v);
    drive_desc(v);
    step();
    step();
    v = '{src:64'h7000, dst:64'h7800, len:64'd4, reps:64'd1, ss:64'h0, ds:64'h0,
          opt:32'h0000_0008, n:1, last_src:64'h7000, last_dst:64'h7800};
    push_exp(v);
    drive_desc(v);
    rsp_valid = 1'b1;
    rsp_last = 1'b0;
    @(negedge clk);
    check("ovl_b_valid", 64'(b_valid), 64'd1);
    step(); rsp_last = 1'b1;
    step();
    @(negedge clk);
    check("ovl_done_a", 64'(nd_done), 64'd1);
    step(); rsp_valid = 1'b0; rsp_last = 1'b0;
    @(negedge clk);
    check("ovl_done_b", 64'(nd_done), 64'd1);
    check("ovl_busy_low", 64'(busy), 64'd0);
    @(negedge clk);
    check("ovl_done_end", 64'(nd_done), 64'd0);
    check("ovl_done_count", 64'(n_done - d0), 64'd2);

    // reset in the middle of a descriptor
    v = '{src:64'h9000, dst:64'hA000, len:64'd8, reps:64'd4, ss:64'h8, ds:64'h8,
          opt:32'h0000_0009, n:4, last_src:64'h9018, last_dst:64'hA018};
    step();
    b0 = n_bursts;
    d0 = n_done;
    push_exp(v);
    drive_desc(v);
    step();
    rst = 1'b1;
    exp_src_q.delete(); exp_dst_q.delete(); exp_len_q.delete(); exp_last_q.delete();
    @(negedge clk);
    check("mid_rst_count", 64'(n_bursts - b0), 64'd1);
    check("mid_rst_valid", 64'(b_valid), 64'd0);
    check("mid_rst_ready", 64'(nd_ready), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_src", b_src, 64'd0);
    step();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_rst_no_done", 64'(n_done - d0), 64'd0);
    check("mid_rst_idle_ready", 64'(nd_ready), 64'd1);
    check("mid_rst_idle_valid", 64'(b_valid), 64'd0);
    check("mid_rst_idle_busy", 64'(busy), 64'd0);

    // zero-length descriptor
    v = '{src:64'hB000, dst:64'hC000, len:64'd0, reps:64'd3, ss:64'h10, ds:64'h10,
          opt:32'h0000_000A, n:0, last_src:64'hB000, last_dst:64'hC000};
    step();
    b0 = n_bursts;
`ifdef IDMA_ND_MIDEND_ZERO_SKIP_EN
    drive_desc(v);
    @(negedge clk);
    check("zs_done", 64'(nd_done), 64'd1);
    check("zs_valid", 64'(b_valid), 64'd0);
    check("zs_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("zs_done_single", 64'(nd_done), 64'd0);
    check("zs_no_burst", 64'(n_bursts - b0), 64'd0);
`else
    v.reps = 64'd1;
    v.n = 1;
    push_exp(v);
    drive_desc(v);
    @(negedge clk);
    check("zl_valid", 64'(b_valid), 64'd1);
    check("zl_len", b_len, 64'd0);
    @(negedge clk);
    check("zl_valid_after", 64'(b_valid), 64'd0);
    step();
    send_rsps(1);
    check_done_pulse("zl");
    check("zl_count", 64'(n_bursts - b0), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
